// File: rtl/tetris_play_ctrl.sv
// Game-play sequencer for a 20x10 field: spawn, gravity and moves, lock, row clearing, game-over.
// Define TETRIS_HARD_DROP_EN to enable the btn_hard hard-drop feature.
module tetris_play_ctrl #(
  parameter int unsigned SPAWN_X = 3,
  parameter int unsigned LINES_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               drop_tick,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_down,
  input  logic               btn_hard,
  input  logic               restart,
  input  logic               collision_bottom,
  input  logic               collision_left,
  input  logic               collision_right,
  input  logic [19:0][9:0]   falling_block_display,
  output logic [4:0]         blockY,
  output logic [3:0]         blockX,
  output logic [19:0][9:0]   stored_array,
  output logic               piece_req,
  output logic [LINES_W-1:0] lines_cleared,
  output logic               game_over
);

  localparam logic [3:0] SpawnX = 4'(SPAWN_X);

  typedef enum logic [2:0] {
    StInit, StSpawn, StCheck, StFall, StLock, StClear, StGameOver
  } state_e;

  state_e state_q, state_d;

  logic [4:0]         block_y_q, block_y_d;
  logic [3:0]         block_x_q, block_x_d;
  logic [19:0][9:0]   stored_q, stored_d;
  logic [LINES_W-1:0] lines_q, lines_d;
  logic [4:0]         scan_row_q, scan_row_d;

  logic fall_lock, fall_down, fall_left, fall_right;
  logic row_full, overlap;

`ifdef TETRIS_HARD_DROP_EN
  logic hard_q, hard_d;
`else
  logic unused_btn_hard;
  assign unused_btn_hard = btn_hard;
`endif

  assign row_full = &stored_q[scan_row_q];
  assign overlap  = |(falling_block_display & stored_q);

  // One FALL action per cycle; lower-priority pulses in the same cycle are dropped.
  always_comb begin
    fall_lock  = 1'b0;
    fall_down  = 1'b0;
    fall_left  = 1'b0;
    fall_right = 1'b0;
`ifdef TETRIS_HARD_DROP_EN
    hard_d = hard_q;
`endif
    if (state_q == StFall) begin
`ifdef TETRIS_HARD_DROP_EN
      if (hard_q || btn_hard) begin
        if (collision_bottom) begin
          fall_lock = 1'b1;
          hard_d    = 1'b0;
        end else begin
          fall_down = 1'b1;
          hard_d    = 1'b1;
        end
      end else
`endif
      if (drop_tick || btn_down) begin
        if (collision_bottom) fall_lock = 1'b1;
        else                  fall_down = 1'b1;
      end else if (btn_left && !btn_right) begin
        fall_left = !collision_left;
      end else if (btn_right && !btn_left) begin
        fall_right = !collision_right;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StInit;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit:     state_d = StSpawn;
      StSpawn:    state_d = StCheck;
      StCheck:    state_d = overlap ? StGameOver : StFall;
      StFall:     if (fall_lock) state_d = StLock;
      StLock:     state_d = StClear;
      StClear:    if (!row_full && scan_row_q == 5'd0) state_d = StSpawn;
      StGameOver: if (restart) state_d = StSpawn;
      default:    state_d = StInit;
    endcase
  end

  always_comb begin
    piece_req = (state_q == StSpawn);
    game_over = (state_q == StGameOver);
  end

  always_comb begin
    block_y_d  = block_y_q;
    block_x_d  = block_x_q;
    stored_d   = stored_q;
    lines_d    = lines_q;
    scan_row_d = scan_row_q;
    case (state_q)
      StSpawn: begin
        block_y_d = 5'd0;
        block_x_d = SpawnX;
      end
      StFall: begin
        if (fall_down)  block_y_d = block_y_q + 5'd1;
        if (fall_left)  block_x_d = block_x_q - 4'd1;
        if (fall_right) block_x_d = block_x_q + 4'd1;
      end
      StLock: begin
        stored_d   = stored_q | falling_block_display;
        scan_row_d = 5'd19;
      end
      StClear: begin
        // A full row collapses everything above it; the same row is re-examined next cycle.
        if (row_full) begin
          for (int r = 1; r < 20; r++) begin
            if (r <= int'(scan_row_q)) stored_d[r] = stored_q[r-1];
          end
          stored_d[0] = '0;
          if (lines_q != '1) lines_d = lines_q + LINES_W'(1);
        end else if (scan_row_q != 5'd0) begin
          scan_row_d = scan_row_q - 5'd1;
        end
      end
      StGameOver: begin
        if (restart) begin
          stored_d = '0;
          lines_d  = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      block_y_q  <= 5'd0;
      block_x_q  <= SpawnX;
      stored_q   <= '0;
      lines_q    <= '0;
      scan_row_q <= 5'd0;
    end else begin
      block_y_q  <= block_y_d;
      block_x_q  <= block_x_d;
      stored_q   <= stored_d;
      lines_q    <= lines_d;
      scan_row_q <= scan_row_d;
    end
  end

`ifdef TETRIS_HARD_DROP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hard_q <= 1'b0;
    else        hard_q <= hard_d;
  end
`endif

  assign blockY        = block_y_q;
  assign blockX        = block_x_q;
  assign stored_array  = stored_q;
  assign lines_cleared = lines_q;

endmodule

// File: tb/tb_tetris_play_ctrl.sv
// Self-checking bench for tetris_play_ctrl: per-cycle comparison against a behavioural model
// plus hand-computed expectations for the directed scenarios.
module tb_tetris_play_ctrl;

  localparam int unsigned SPAWN_X = 3;
  localparam int unsigned LINES_W = 16;

  localparam logic [5:0] DROP    = 6'b000001;
  localparam logic [5:0] LEFT    = 6'b000010;
  localparam logic [5:0] RIGHT   = 6'b000100;
  localparam logic [5:0] DOWN    = 6'b001000;
  localparam logic [5:0] RESTART = 6'b010000;
  localparam logic [5:0] HARD    = 6'b100000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic drop_tick = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_down = 1'b0;
  logic btn_hard = 1'b0, restart = 1'b0;
  logic collision_bottom = 1'b0, collision_left = 1'b0, collision_right = 1'b0;
  logic [19:0][9:0]   falling_block_display = '0;
  logic [4:0]         blockY;
  logic [3:0]         blockX;
  logic [19:0][9:0]   stored_array;
  logic               piece_req;
  logic [LINES_W-1:0] lines_cleared;
  logic               game_over;

  tetris_play_ctrl #(.SPAWN_X(SPAWN_X), .LINES_W(LINES_W)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .drop_tick             (drop_tick),
    .btn_left              (btn_left),
    .btn_right             (btn_right),
    .btn_down              (btn_down),
    .btn_hard              (btn_hard),
    .restart               (restart),
    .collision_bottom      (collision_bottom),
    .collision_left        (collision_left),
    .collision_right       (collision_right),
    .falling_block_display (falling_block_display),
    .blockY                (blockY),
    .blockX                (blockX),
    .stored_array          (stored_array),
    .piece_req             (piece_req),
    .lines_cleared         (lines_cleared),
    .game_over             (game_over)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: modes describe what the game is doing, row clearing is resolved in one go.
  typedef enum {MdInit, MdSpawn, MdCheck, MdFall, MdLock, MdClear, MdOver} mode_t;
  mode_t            m_mode;
  logic [4:0]       m_y;
  logic [3:0]       m_x;
  logic [19:0][9:0] m_stored, m_final;
  int               m_lines, m_final_lines, m_clear_left;
`ifdef TETRIS_HARD_DROP_EN
  bit               m_hard;
`endif

  task automatic chk(input string name, input logic [199:0] got, input logic [199:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode   = MdInit;
    m_y      = 5'd0;
    m_x      = 4'(SPAWN_X);
    m_stored = '0;
    m_lines  = 0;
`ifdef TETRIS_HARD_DROP_EN
    m_hard   = 1'b0;
`endif
  endtask

  // Remove every full row, let the rest fall, and note how long the one-row-per-cycle scan takes.
  task automatic settle();
    logic [9:0] keep[$];
    int n;
    int max_lines;
    n = 0;
    max_lines = (1 << LINES_W) - 1;
    for (int r = 19; r >= 0; r--) begin
      if (m_stored[r] == 10'h3FF) n++;
      else keep.push_back(m_stored[r]);
    end
    for (int r = 19; r >= 0; r--) m_final[r] = (19 - r < keep.size()) ? keep[19-r] : 10'h000;
    m_final_lines = (m_lines + n > max_lines) ? max_lines : m_lines + n;
    m_clear_left  = 20 + n;
  endtask

  task automatic fall_step();
    bit hard_now;
    hard_now = 1'b0;
`ifdef TETRIS_HARD_DROP_EN
    hard_now = m_hard || btn_hard;
`endif
    if (hard_now) begin
      if (collision_bottom) begin
        m_mode = MdLock;
`ifdef TETRIS_HARD_DROP_EN
        m_hard = 1'b0;
`endif
      end else begin
        m_y = m_y + 5'd1;
`ifdef TETRIS_HARD_DROP_EN
        m_hard = 1'b1;
`endif
      end
    end else if (drop_tick || btn_down) begin
      if (collision_bottom) m_mode = MdLock;
      else                  m_y = m_y + 5'd1;
    end else if (btn_left && !btn_right) begin
      if (!collision_left) m_x = m_x - 4'd1;
    end else if (btn_right && !btn_left) begin
      if (!collision_right) m_x = m_x + 4'd1;
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_mode == MdInit) m_mode = MdSpawn;
    else if (m_mode == MdSpawn) begin
      m_mode = MdCheck;
      m_y    = 5'd0;
      m_x    = 4'(SPAWN_X);
    end else if (m_mode == MdCheck) begin
      m_mode = ((falling_block_display & m_stored) != '0) ? MdOver : MdFall;
    end else if (m_mode == MdFall) fall_step();
    else if (m_mode == MdLock) begin
      m_stored = m_stored | falling_block_display;
      settle();
      m_mode = MdClear;
    end else if (m_mode == MdClear) begin
      m_clear_left--;
      if (m_clear_left == 0) begin
        m_stored = m_final;
        m_lines  = m_final_lines;
        m_mode   = MdSpawn;
      end
    end else if (m_mode == MdOver) begin
      if (restart) begin
        m_stored = '0;
        m_lines  = 0;
        m_mode   = MdSpawn;
      end
    end
  endtask

  task automatic compare();
    chk("blockY", 200'(blockY), 200'(m_y));
    chk("blockX", 200'(blockX), 200'(m_x));
    chk("piece_req", 200'(piece_req), 200'(m_mode == MdSpawn));
    chk("game_over", 200'(game_over), 200'(m_mode == MdOver));
    // Mid-clear snapshots are implementation timing; the settled result is checked at spawn.
    if (m_mode != MdClear) begin
      chk("stored_array", 200'(stored_array), 200'(m_stored));
      chk("lines_cleared", 200'(lines_cleared), 200'(m_lines));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic press(input logic [5:0] m);
    {btn_hard, restart, btn_down, btn_right, btn_left, drop_tick} = m;
    tick();
    {btn_hard, restart, btn_down, btn_right, btn_left, drop_tick} = '0;
  endtask

  task automatic assert_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare();
  endtask

  task automatic release_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_spawn(input int budget, output int n);
    n = 0;
    while (piece_req !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    if (piece_req !== 1'b1) chk("spawn_timeout", 200'(piece_req), 200'(1));
  endtask

  initial begin
    int n;
    logic [19:0][9:0] exp_arr;

    assert_reset();
    chk("reset_blockX", 200'(blockX), 200'(3));
    chk("reset_piece_req", 200'(piece_req), 200'(0));
    release_reset();

    tick();
    chk("spawn_piece_req", 200'(piece_req), 200'(1));
    chk("spawn_blockX", 200'(blockX), 200'(3));
    tick();
    chk("check_piece_req", 200'(piece_req), 200'(0));
    tick();

    press(DROP | LEFT);
    chk("drop_wins_y", 200'(blockY), 200'(1));
    chk("drop_wins_x", 200'(blockX), 200'(3));
    press(LEFT);
    chk("left_x", 200'(blockX), 200'(2));
    press(LEFT | RIGHT);
    chk("both_ignored", 200'(blockX), 200'(2));
    press(DOWN);
    press(RESTART);
    press(LEFT);
    press(LEFT);
    chk("at_col0", 200'(blockX), 200'(0));
    collision_left = 1'b1;
    press(LEFT);
    chk("wall_left", 200'(blockX), 200'(0));
    collision_left = 1'b0;
    press(RIGHT);
    collision_right = 1'b1;
    press(RIGHT);
    chk("wall_right", 200'(blockX), 200'(1));
    collision_right = 1'b0;

    // Lock a partial piece: no full rows, so only the 20-row scan runs.
    falling_block_display     = '0;
    falling_block_display[19] = 10'h0FF;
    falling_block_display[18] = 10'h0FF;
    falling_block_display[17] = 10'h001;
    collision_bottom = 1'b1;
    press(DROP);
    chk("lock_hold_y", 200'(blockY), 200'(2));
    wait_spawn(40, n);
    chk("scan_only_cycles", 200'(n), 200'(21));
    exp_arr = '0;
    exp_arr[19] = 10'h0FF;
    exp_arr[18] = 10'h0FF;
    exp_arr[17] = 10'h001;
    chk("lock_merge", 200'(stored_array), 200'(exp_arr));
    collision_bottom = 1'b0;

    // Second piece completes rows 19 and 18.
    falling_block_display     = '0;
    falling_block_display[19] = 10'h300;
    falling_block_display[18] = 10'h300;
    tick();
    tick();
    chk("respawn_y", 200'(blockY), 200'(0));
    collision_bottom = 1'b1;
    press(DROP);
    wait_spawn(40, n);
    chk("two_clear_cycles", 200'(n), 200'(23));
    exp_arr = '0;
    exp_arr[19] = 10'h001;
    chk("two_clear_array", 200'(stored_array), 200'(exp_arr));
    chk("two_clear_lines", 200'(lines_cleared), 200'(2));
    collision_bottom = 1'b0;

    // Spawn onto an occupied cell.
    falling_block_display     = '0;
    falling_block_display[19] = 10'h001;
    tick();
    tick();
    chk("game_over_set", 200'(game_over), 200'(1));
    press(DROP | LEFT | DOWN);
    chk("game_over_hold", 200'(game_over), 200'(1));
    press(RESTART);
    chk("restart_piece_req", 200'(piece_req), 200'(1));
    chk("restart_stored", 200'(stored_array), 200'(0));
    chk("restart_lines", 200'(lines_cleared), 200'(0));
    chk("restart_game_over", 200'(game_over), 200'(0));
    falling_block_display = '0;
    tick();
    tick();

`ifdef TETRIS_HARD_DROP_EN
    press(HARD);
    chk("hard_first_step", 200'(blockY), 200'(1));
    n = 0;
    while (blockY != 5'd15 && n < 30) begin
      tick();
      n++;
    end
    chk("hard_reach_15", 200'(blockY), 200'(15));
    collision_bottom = 1'b1;
    tick();
    chk("hard_lock_y", 200'(blockY), 200'(15));
    wait_spawn(40, n);
    chk("hard_scan_cycles", 200'(n), 200'(21));
    collision_bottom = 1'b0;
    tick();
    tick();
`else
    press(HARD);
    chk("hard_ignored", 200'(blockY), 200'(0));
`endif

    // Reset in the middle of a clear must discard the partial shift.
    falling_block_display     = '0;
    falling_block_display[19] = 10'h3FF;
    collision_bottom = 1'b1;
    press(DROP);
    collision_bottom = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_clear_lines", 200'(lines_cleared), 200'(1));
    assert_reset();
    chk("midreset_stored", 200'(stored_array), 200'(0));
    chk("midreset_lines", 200'(lines_cleared), 200'(0));
    chk("midreset_blockX", 200'(blockX), 200'(3));
    falling_block_display = '0;
    release_reset();
    tick();
    chk("post_reset_spawn", 200'(piece_req), 200'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tetris_play_ctrl.md
Name: tetris_play_ctrl

Overview:
- Game-play sequencer for the 20x10 playfield.
- Owns the settled-block array (`stored_array`) and the falling-piece position (`blockY`/`blockX`).
- Drives the combinational collision checker with `blockY`/`blockX`/`stored_array` and consumes its three collision flags and its `falling_block_display`.
- Sequences spawn, gravity and player moves, lock, row clearing and game-over; requests new pieces from the piece generator.

Parameters:
- SPAWN_X, 3: column loaded into `blockX` on spawn (0..6).
- LINES_W, 16: width of the cleared-lines counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- drop_tick  in  1  gravity pulse, 1 cycle
- btn_left  in  1  move-left pulse, debounced upstream, 1 cycle
- btn_right  in  1  move-right pulse, 1 cycle
- btn_down  in  1  soft-drop pulse, 1 cycle
- btn_hard  in  1  hard-drop pulse (see Optional Feature)
- restart  in  1  leave game-over
- collision_bottom  in  1  from collision checker
- collision_left  in  1  from collision checker
- collision_right  in  1  from collision checker
- falling_block_display  in  [19:0][9:0]  current piece cells, from collision checker
- blockY  out  5  piece row origin, registered
- blockX  out  4  piece column origin, registered
- stored_array  out  [19:0][9:0]  settled cells, registered
- piece_req  out  1  pulse: generator presents next pattern on following cycle
- lines_cleared  out  LINES_W  total rows cleared, saturating
- game_over  out  1  high while in GAMEOVER

Behaviour:
- Reset values (async on `rst_n`=0):
  - state=INIT
  - blockY=0, blockX=SPAWN_X
  - stored_array=0, lines_cleared=0
  - game_over=0, piece_req=0
- States: INIT, SPAWN, CHECK, FALL, LOCK, CLEAR, GAMEOVER. `scan_row` is a 5-bit internal register.
- INIT: next cycle -> SPAWN.
- SPAWN (1 cycle):
  - `piece_req`=1 (combinational, only in SPAWN).
  - Load blockY=0, blockX=SPAWN_X.
  - -> CHECK.
- CHECK (1 cycle):
  - New pattern is now valid.
  - If |(falling_block_display & stored_array) -> GAMEOVER, else -> FALL.
- FALL: at most one action per cycle, evaluated on the current registered position. Priority order:
  1. `drop_tick` or `btn_down`: if collision_bottom -> LOCK (position held), else blockY+1.
  2. `btn_left` and !`btn_right`: if !collision_left, blockX-1.
  3. `btn_right` and !`btn_left`: if !collision_right, blockX+1.
  4. `btn_left` and `btn_right` together: ignored.
  - Lower-priority pulses arriving in the same cycle are dropped, not queued.
- LOCK (1 cycle):
  - stored_array <= stored_array | falling_block_display.
  - scan_row=19; -> CLEAR.
- CLEAR: one row examined per cycle.
  - If &stored_array[scan_row]:
    - rows r=scan_row..1 take row r-1; row 0 <= 0.
    - lines_cleared+1, saturating at all-ones.
    - scan_row unchanged; the same row is re-examined next cycle.
  - Else if scan_row==0 -> SPAWN.
  - Else scan_row-1.
  - Worst case is 24 cycles (4 clears + 20 scans).
- GAMEOVER:
  - game_over=1; all buttons and ticks ignored.
  - On `restart`: stored_array=0, lines_cleared=0, game_over=0; -> SPAWN.
  - `restart` is ignored in every other state.
- Inputs outside FALL (except `restart` in GAMEOVER) are ignored.
- `rst_n` assertion mid-operation (e.g. mid-CLEAR) returns everything to reset values immediately; no partial shift survives.
- Width rules:
  - blockY and blockX never leave 0..19 and 0..9; the collision flags guarantee this.
  - No wrap on blockX-1 at column 0, because collision_left is set there.

Optional Feature:
- Macro TETRIS_HARD_DROP_EN.
- Defined:
  - In FALL, `btn_hard` (highest priority, above `drop_tick`) sets an internal hard flag.
  - While the flag is set: one row per cycle (blockY+1) while !collision_bottom; all other inputs ignored.
  - On collision_bottom -> LOCK and the flag clears.
  - Flag is cleared by reset.
- Undefined: `btn_hard` is ignored; no flag logic is synthesized.

Test Plan:
- Release reset, drive collision flags 0 -> INIT, then SPAWN with piece_req=1 for exactly 1 cycle, blockY=0, blockX=3; CHECK with no overlap -> FALL.
- FALL, `drop_tick` and `btn_left` in same cycle, collision_bottom=0 -> blockY 0->1, blockX stays 3; `btn_left` alone next cycle -> blockX=2; `btn_left`+`btn_right` -> no change.
- blockX=0, collision_left=1, `btn_left` -> blockX stays 0; collision_bottom=1 with `drop_tick` -> LOCK, stored_array gains the display cells.
- Lock a piece filling rows 19 and 18, each otherwise full, with a single cell at row 17 col 0 -> 2 clear cycles; lines_cleared=2; row 19 = old row 17 pattern; rows 0..18 as shifted; -> SPAWN after scan reaches 0.
- Spawn with falling_block_display overlapping stored_array in CHECK -> GAMEOVER, game_over=1, `drop_tick` ignored; `restart` -> stored_array=0, lines_cleared=0, piece_req pulse.
- With TETRIS_HARD_DROP_EN, `btn_hard` at blockY=0, collision_bottom rising when blockY=15 -> blockY increments each cycle to 15, LOCK on the next cycle; without the macro -> blockY unchanged.
